// File: rtl/dcpu16_bus_arb_if.sv
// -----------------------------------------------------------------------------
// dcpu16_bus_arb_if
// Shared bus bundle between N requesting masters, the arbiter and one slave.
//
// Parameters: NCH (master channels), AW (address width), DW (data width).
//
// Signals:
//   m_stb[NCH]      per-master request strobe
//   m_wre[NCH]      per-master write enable
//   m_adr[NCH*AW]   per-master address, channel i at [i*AW +: AW]
//   m_dto[NCH*DW]   per-master write data, channel i at [i*DW +: DW]
//   m_dti[DW]       read data broadcast to every master
//   m_ack[NCH]      per-master acknowledge
//   s_stb/s_wre/s_adr/s_dto   slave request side
//   s_dti/s_ack               slave response side
//   gnt[NCH]        one-hot registered grant
//   busy            arbiter owns a transfer
//   tmo             single-cycle pulse on a timeout termination
//
// Modports:
//   master : the surroundings of the arbiter (the requesting masters and
//            the memory slave); drives requests and slave responses.
//   slave  : the arbiter itself; serves the masters and drives the slave.
// -----------------------------------------------------------------------------
interface dcpu16_bus_arb_if #(
    parameter int NCH = 2,
    parameter int AW  = 16,
    parameter int DW  = 16
);
    logic [NCH-1:0]    m_stb;
    logic [NCH-1:0]    m_wre;
    logic [NCH*AW-1:0] m_adr;
    logic [NCH*DW-1:0] m_dto;
    logic [DW-1:0]     m_dti;
    logic [NCH-1:0]    m_ack;
    logic              s_stb;
    logic              s_wre;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dto;
    logic [DW-1:0]     s_dti;
    logic              s_ack;
    logic [NCH-1:0]    gnt;
    logic              busy;
    logic              tmo;

    modport master (
        output m_stb, m_wre, m_adr, m_dto, s_dti, s_ack,
        input  m_dti, m_ack, s_stb, s_wre, s_adr, s_dto, gnt, busy, tmo
    );

    modport slave (
        input  m_stb, m_wre, m_adr, m_dto, s_dti, s_ack,
        output m_dti, m_ack, s_stb, s_wre, s_adr, s_dto, gnt, busy, tmo
    );
endinterface

// File: rtl/dcpu16_bus_arb.sv
// -----------------------------------------------------------------------------
// dcpu16_bus_arb
// N-master to 1-slave bus arbiter with strobe/ack handshake. Folds the CPU's
// separate bus ports (and any DMA/peripheral masters) onto one memory port.
//
// Parameters:
//   NCH  : master channels (2..8)
//   AW   : address width
//   DW   : data width
//   MODE : 0 = fixed priority (lowest index wins), 1 = round-robin
//   TMO  : BUSY cycles before a forced ack; 0 disables the timeout
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dcpu16_bus_arb_if.slave (master requests, slave port, status)
//
// Operation: in IDLE a pending request is granted on the next edge (gnt is
// registered), in BUSY the granted master is muxed onto the slave port and
// s_ack is passed straight back. Any termination (ack, abort, timeout)
// returns to IDLE, giving one dead cycle between transfers.
// -----------------------------------------------------------------------------
module dcpu16_bus_arb #(
    parameter int NCH  = 2,
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int MODE = 1,
    parameter int TMO  = 0
) (
    input  logic           clk,
    input  logic           rst,
    dcpu16_bus_arb_if.slave bus
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [NCH-1:0] r_gnt,   w_gnt_nxt;
    logic [PW-1:0]  r_ptr,   w_ptr_nxt;
    logic [CW-1:0]  r_cnt,   w_cnt_nxt;

    logic [PW-1:0]  w_sel;
    logic           w_any;
    logic           w_stb_k;
    logic           w_wre_k;
    logic [AW-1:0]  w_adr_k;
    logic [DW-1:0]  w_dto_k;
    logic           w_tmo;
    logic           w_done;

    // Request selection. The loops run from the least to the most preferred
    // candidate so that the last hit, i.e. the winner, overwrites the others.
    always_comb begin
        int idx;
        idx   = 0;
        w_sel = '0;
        w_any = |bus.m_stb;
        if (MODE == 0) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (bus.m_stb[i]) w_sel = PW'(i);
            end
        end else begin
            // Search ptr+1, ptr+2, ... with wrap; ptr itself is searched last.
            for (int i = NCH; i >= 1; i--) begin
                idx = (int'(r_ptr) + i) % NCH;
                if (bus.m_stb[idx]) w_sel = PW'(idx);
            end
        end
    end

    // Granted-channel mux; all zero while gnt is zero, which also gates the
    // slave port in IDLE.
    always_comb begin
        w_stb_k = 1'b0;
        w_wre_k = 1'b0;
        w_adr_k = '0;
        w_dto_k = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_gnt[i]) begin
                w_stb_k = bus.m_stb[i];
                w_wre_k = bus.m_wre[i];
                w_adr_k = bus.m_adr[i*AW +: AW];
                w_dto_k = bus.m_dto[i*DW +: DW];
            end
        end
    end

    // Forced ack on the last allowed BUSY cycle. A real s_ack in the same
    // cycle takes precedence, and a withdrawn request is an abort, not a
    // timeout, so neither produces a tmo pulse.
    always_comb begin
        w_tmo = (TMO > 0) && (r_state == ST_BUSY) && w_stb_k && !bus.s_ack &&
                (r_cnt == CW'(TMO - 1));
        w_done = bus.s_ack || w_tmo || !w_stb_k;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= PW'(NCH - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_any) begin
                    w_state_nxt = ST_BUSY;
                    w_gnt_nxt   = NCH'(1) << w_sel;
                    w_ptr_nxt   = w_sel;
                end
            end
            ST_BUSY: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (TMO > 0) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.s_stb = w_stb_k & ~w_tmo;
    assign bus.s_wre = w_wre_k;
    assign bus.s_adr = w_adr_k;
    assign bus.s_dto = w_dto_k;
    assign bus.m_ack = r_gnt & {NCH{bus.s_ack | w_tmo}};
    assign bus.m_dti = bus.s_dti;
    assign bus.gnt   = r_gnt;
    assign bus.busy  = (r_state == ST_BUSY);
    assign bus.tmo   = w_tmo;

endmodule

// File: doc/dcpu16_bus_arb.md
Name: dcpu16_bus_arb

Overview:
- Parametrised N-master to 1-slave bus arbiter with strobe/ack handshake. It generalises the CPU's separate FBUS/ABUS ports onto a single shared memory port.
- Supports fixed-priority or round-robin grant, configurable address/data width and channel count, and an optional ack timeout.
- Sits between dcpu16_cpu bus ports (and DMA/peripheral masters) and the memory/slave interface.

Parameters:
- NCH, 2, number of master channels (2..8).
- AW, 16, address width.
- DW, 16, data width.
- MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- TMO, 0, timeout in BUSY cycles before a forced ack. 0 disables the timeout.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- m_stb  in  NCH  per-master request strobe.
- m_wre  in  NCH  per-master write enable.
- m_adr  in  NCH*AW  per-master address, channel i at [i*AW +: AW].
- m_dto  in  NCH*DW  per-master write data, channel i at [i*DW +: DW].
- m_dti  out  DW  read data broadcast to all masters (= s_dti).
- m_ack  out  NCH  per-master acknowledge.
- s_stb  out  1  slave strobe.
- s_wre  out  1  slave write enable.
- s_adr  out  AW  slave address.
- s_dto  out  DW  slave write data.
- s_dti  in  DW  slave read data.
- s_ack  in  1  slave acknowledge.
- gnt  out  NCH  one-hot registered grant.
- busy  out  1  arbiter in BUSY state.
- tmo  out  1  one-cycle pulse on timeout termination.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset values: state IDLE, gnt=0, busy=0, tmo=0, round-robin pointer=NCH-1 (so channel 0 is searched first), timeout counter=0.
- Output gating: s_stb, s_wre, s_adr, s_dto and m_ack are all 0 whenever gnt=0.
- FSM state IDLE:
  - If any m_stb is set, register gnt for the selected channel and go to BUSY on the next edge.
  - Arbitration latency is exactly 1 cycle from m_stb to s_stb.
- Selection rule:
  - MODE=0: lowest set index wins.
  - MODE=1: first set index searching ptr+1, ptr+2, … with wrap modulo NCH. ptr is updated to the granted index when the grant is registered.
- FSM state BUSY (k = granted index):
  - s_stb=m_stb[k], s_wre=m_wre[k], s_adr=m_adr[k], s_dto=m_dto[k]. These are a combinational mux from the registered gnt.
  - m_ack[k]=s_ack, combinational pass-through, same cycle. m_ack of every other channel stays 0.
- Completion: s_ack=1 in BUSY goes to IDLE next edge and clears gnt. The bus then has one dead (IDLE) cycle before the next grant, so maximum throughput is 1 transfer per 2 cycles.
- Withdrawn request: m_stb[k]=0 while in BUSY with no s_ack is a master abort. Go to IDLE next edge with no ack issued.
- Timeout (TMO>0):
  - The counter increments each BUSY cycle without s_ack and clears on entry to IDLE.
  - When the count reaches TMO-1 and s_ack=0 in that cycle, the arbiter drives m_ack[k]=1 and tmo=1 for that single cycle, with s_stb forced to 0. It then goes to IDLE next edge.
  - m_dti is undefined on a timeout ack.
- Simultaneous s_ack and timeout in the same cycle: s_ack wins and tmo stays 0.
- Reset mid-transfer: rst during BUSY forces IDLE at the next edge. s_stb and m_ack drop that edge, and no ack is delivered.
- Channels whose stb is held while not granted see m_ack=0 and simply wait. No request is lost.
- m_dti = s_dti at all times, combinational.

Test Plan:
- Fixed priority: MODE=0, NCH=2, m_stb=2'b11, s_ack returned 1 cycle after s_stb. Required: gnt=01 first, m_ack[0] pulses, IDLE cycle, then gnt=10 and m_ack[1] pulses. Channel 0 re-requesting at once starves channel 1.
- Round-robin: MODE=1, NCH=4, all m_stb held high. Required: grant order 0,1,2,3,0. s_adr matches m_adr of the granted channel each transfer (addresses 0x1000+i).
- Read/write data: master 1 writes 0xBEEF to 0x0042 (s_wre=1, s_dto=0xBEEF), then reads with s_dti=0x1234. Required: m_dti=0x1234 in the m_ack[1] cycle.
- Timeout: TMO=4, slave never acks. Required: m_ack[k]=1 and tmo=1 in the 4th BUSY cycle, IDLE next edge. With s_ack=1 in that same cycle instead, tmo=0.
- Abort: m_stb[0] dropped in the 2nd BUSY cycle with no ack. Required: IDLE next edge, no m_ack, and a pending channel 1 is granted on the following edge.
- Reset mid-op: rst=1 during BUSY. Required: gnt=0, busy=0, s_stb=0 after the edge. Round-robin restarts at channel 0.
